// File: rtl/wb_stage_pkg.sv
// Write-back stage types, widths and opcode classification helper.
// Combinational helper only, zero latency.
// No flow control here; the stage itself owns stall handling.
`ifndef WB_OPCODES_SV
`include "wb_opcodes.sv"
`endif

package wb_stage_pkg;

    localparam int REG_AW = `WB_REG_AW;
    localparam int DATA_W = `WB_DATA_W;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_ALU_LO = `NOP + 5'd1;
    localparam logic [OPC_W-1:0] OP_ALU_HI = `ARSH;

    // How the write-back value is produced for a given opcode.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,  // ALU result written
        WB_SEL_LMD  = 2'd1,  // load data written
        WB_SEL_NONE = 2'd2,  // legal but writes nothing (NOP, STR)
        WB_SEL_ILL  = 2'd3   // unknown opcode
    } wb_sel_e;

    function automatic wb_sel_e wb_classify(input logic [OPC_W-1:0] op);
        wb_sel_e sel;
        if (op == `LDW)
            sel = WB_SEL_LMD;
        else if (op >= OP_ALU_LO && op <= OP_ALU_HI)
            sel = WB_SEL_ALU;
        else if (op == `NOP || op == `STR)
            sel = WB_SEL_NONE;
        else
            sel = WB_SEL_ILL;
        return sel;
    endfunction

endpackage

// File: rtl/wb_fwd_hist.sv
// Two-entry history of performed register-file writes for EX bypassing.
// Entries load on the same edge that the write enable register asserts.
// No backpressure: shifts only when a write is actually performed.
import wb_stage_pkg::*;

module wb_fwd_hist (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              fwd0_valid_o,
    output logic [REG_AW-1:0] fwd0_addr_o,
    output logic [DATA_W-1:0] fwd0_data_o,
    output logic              fwd1_valid_o,
    output logic [REG_AW-1:0] fwd1_addr_o,
    output logic [DATA_W-1:0] fwd1_data_o
);

    logic              v0_q, v1_q;
    logic [REG_AW-1:0] a0_q, a1_q;
    logic [DATA_W-1:0] d0_q, d1_q;

    // Shift the newest write into slot 0, age slot 0 into slot 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            a0_q <= '0;
            a1_q <= '0;
            d0_q <= '0;
            d1_q <= '0;
        end else if (wr_en_i) begin
            v1_q <= v0_q;
            a1_q <= a0_q;
            d1_q <= d0_q;
            v0_q <= 1'b1;
            a0_q <= wr_addr_i;
            d0_q <= wr_data_i;
        end
    end

    assign fwd0_valid_o = v0_q;
    assign fwd0_addr_o  = a0_q;
    assign fwd0_data_o  = d0_q;
    assign fwd1_valid_o = v1_q;
    assign fwd1_addr_o  = a1_q;
    assign fwd1_data_o  = d1_q;

endmodule

// File: rtl/wb_opcodes.sv
// Shared opcode encodings and datapath widths for the pipeline stages.
// Pure definitions, no logic, no latency.
// Include-guarded so any number of files can pull it in.
`ifndef WB_OPCODES_SV
`define WB_OPCODES_SV

`define NOP   5'h00
`define ADD   5'h01
`define SUB   5'h02
`define AND   5'h03
`define OR    5'h04
`define XOR   5'h05
`define SLT   5'h06
`define SLTU  5'h07
`define LSH   5'h08
`define RSH   5'h09
`define ADDI  5'h0A
`define MUL   5'h0B
`define ARSH  5'h0C
`define LDW   5'h10
`define STR   5'h11

`define WB_REG_AW 4
`define WB_DATA_W 32

`endif

// File: rtl/wb_stage.sv
// Write-back stage: registers memory-stage results and drives the RF write port.
// Latency 1 cycle from accept to rf_we/rf_waddr/rf_wdata/retired_pc.
// stall freezes all state and drops rf_we; optional history under WB_BYPASS_EN.
import wb_stage_pkg::*;

module wb_stage #(
    parameter int CNT_W       = 16,
    parameter bit ZERO_REG_RO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [4:0]        pc_in,
    input  logic [4:0]        opcode_in,
    input  logic [31:0]       lmd_in,
    input  logic [31:0]       alu_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        mem_src_in,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [4:0]        retired_pc,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              illegal_op,
    output logic              fwd0_valid,
    output logic [3:0]        fwd0_addr,
    output logic [31:0]       fwd0_data,
    output logic              fwd1_valid,
    output logic [3:0]        fwd1_addr,
    output logic [31:0]       fwd1_data
);

    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ill_q, ill_d;

    logic    accept;
    wb_sel_e sel;
    logic    zero_dest_blocked;

    // Load source address is carried for tracing only and is not stored.
    logic unused_mem_src;
    assign unused_mem_src = ^mem_src_in;

    assign accept            = in_valid && !stall;
    assign sel               = wb_classify(opcode_in);
    assign zero_dest_blocked = ZERO_REG_RO && (dest_in == '0);

    // Next state: everything holds unless an instruction is accepted;
    // the write enable is a one-shot so a stall never repeats a write.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        if (accept) begin
            waddr_d = dest_in;
            wdata_d = (sel == WB_SEL_LMD) ? lmd_in : alu_in;
            pc_d    = pc_in;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            we_d    = (sel == WB_SEL_ALU || sel == WB_SEL_LMD) && !zero_dest_blocked;
            if (sel == WB_SEL_ILL)
                ill_d = 1'b1;
        end
    end

    // Stage registers; reset wins over any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign retired_pc = pc_q;
    assign retire_cnt = cnt_q;
    assign illegal_op = ill_q;

`ifdef WB_BYPASS_EN
    // History is fed from next-state values so it tracks rf_we cycle-exactly.
    wb_fwd_hist u_fwd_hist (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (we_d),
        .wr_addr_i    (waddr_d),
        .wr_data_i    (wdata_d),
        .fwd0_valid_o (fwd0_valid),
        .fwd0_addr_o  (fwd0_addr),
        .fwd0_data_o  (fwd0_data),
        .fwd1_valid_o (fwd1_valid),
        .fwd1_addr_o  (fwd1_addr),
        .fwd1_data_o  (fwd1_data)
    );
`else
    assign fwd0_valid = 1'b0;
    assign fwd0_addr  = '0;
    assign fwd0_data  = '0;
    assign fwd1_valid = 1'b0;
    assign fwd1_addr  = '0;
    assign fwd1_data  = '0;
`endif

endmodule
